// File: rtl/ram_lsu_master.sv
// Load/store unit driving a word-addressed, byte-enabled RAM port; optional misaligned split via LSU_SPLIT_EN.
// Latency accept->rsp_valid: store 2, load 3, fault 1 (split: store 3, load 4); all mem_* outputs are registered.
// Backpressure: req_ready only in IDLE (one request in flight); rsp_valid is a one-cycle pulse with no backpressure.
module ram_lsu_master #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic              mem_wren,
    output logic [ADDR_W-3:0] mem_address,
    output logic [31:0]       mem_data,
    output logic [3:0]        mem_byteena,
    input  logic [31:0]       mem_q
);

    localparam int WA = ADDR_W - 2;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ISSUE2, S_DATA, S_RESP} state_t;

    state_t state_q, state_d;

    logic        accept, misal, fault_in;
    logic [3:0]  size_mask;
    logic [31:0] lo_dat;
    logic [3:0]  lo_be;

    // request fields captured at accept
    logic        we_q, sgn_q;
    logic [1:0]  size_q, off_q;

    logic [31:0] lanes, result;

    // next values of the registered outputs
    logic          wren_d, valid_d, fault_d, ready_d;
    logic [WA-1:0] addr_d;
    logic [31:0]   dat_d, rdata_d;
    logic [3:0]    be_d;

    assign accept = req_valid & req_ready;

    // classify the incoming request and build its unshifted lane mask
    always_comb begin
        misal = ((req_size == 2'd1) && req_addr[0]) ||
                ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
        case (req_size)
            2'd0:    size_mask = 4'b0001;
            2'd1:    size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

`ifdef LSU_SPLIT_EN
    // 64-bit lane view: low half goes to word A, high half to word A+1
    logic [63:0] wide_dat;
    logic [7:0]  wide_be;
    logic        split_q;
    logic [31:0] hi_dat_q, lo_q;
    logic [3:0]  hi_be_q;

    assign wide_dat = {32'd0, req_wdata} << {req_addr[1:0], 3'b000};
    assign wide_be  = {4'd0, size_mask} << req_addr[1:0];
    assign lo_dat   = wide_dat[31:0];
    assign lo_be    = wide_be[3:0];
    assign fault_in = (req_size == 2'd3);

    // hold the second-word lanes and the first-word read data for the split access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            split_q  <= 1'b0;
            hi_dat_q <= '0;
            hi_be_q  <= '0;
            lo_q     <= '0;
        end else begin
            if (accept) begin
                split_q  <= misal;
                hi_dat_q <= wide_dat[63:32];
                hi_be_q  <= wide_be[7:4];
            end
            if (state_q == S_ISSUE2)
                lo_q <= mem_q;
        end
    end

    assign lanes = split_q ? 32'({mem_q, lo_q} >> {off_q, 3'b000})
                           : (mem_q >> {off_q, 3'b000});
`else
    assign lo_dat   = req_wdata << {req_addr[1:0], 3'b000};
    assign lo_be    = size_mask << req_addr[1:0];
    assign fault_in = (req_size == 2'd3) | misal;
    assign lanes    = mem_q >> {off_q, 3'b000};
`endif

    // truncate the right-justified read data to the access size and extend
    always_comb begin
        case (size_q)
            2'd0:    result = {{24{sgn_q & lanes[7]}}, lanes[7:0]};
            2'd1:    result = {{16{sgn_q & lanes[15]}}, lanes[15:0]};
            default: result = lanes;
        endcase
    end

    // capture the request so later req_* changes are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            sgn_q  <= 1'b0;
            size_q <= 2'd0;
            off_q  <= 2'd0;
        end else if (accept) begin
            we_q   <= req_we;
            sgn_q  <= req_signed;
            size_q <= req_size;
            off_q  <= req_addr[1:0];
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = fault_in ? S_RESP : S_ISSUE;
            S_ISSUE: begin
                state_d = we_q ? S_RESP : S_DATA;
`ifdef LSU_SPLIT_EN
                if (split_q) state_d = S_ISSUE2;
`endif
            end
`ifdef LSU_SPLIT_EN
            S_ISSUE2: state_d = we_q ? S_RESP : S_DATA;
`endif
            S_DATA:  state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // next values for the registered RAM-side and response outputs
    always_comb begin
        wren_d  = 1'b0;
        addr_d  = mem_address;
        dat_d   = mem_data;
        be_d    = mem_byteena;
        fault_d = 1'b0;
        rdata_d = '0;
        valid_d = (state_d == S_RESP);
        ready_d = (state_d == S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (fault_in) begin
                        fault_d = 1'b1;
                    end else begin
                        wren_d = req_we;
                        addr_d = req_addr[ADDR_W-1:2];
                        dat_d  = lo_dat;
                        be_d   = lo_be;
                    end
                end
            end
`ifdef LSU_SPLIT_EN
            S_ISSUE: begin
                if (split_q) begin
                    wren_d = we_q;
                    addr_d = mem_address + WA'(1);
                    dat_d  = hi_dat_q;
                    be_d   = hi_be_q;
                end
            end
`endif
            S_DATA:  rdata_d = result;
            default: ;
        endcase
    end

    // output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_fault   <= 1'b0;
            mem_wren    <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_byteena <= '0;
        end else begin
            req_ready   <= ready_d;
            rsp_valid   <= valid_d;
            rsp_rdata   <= rdata_d;
            rsp_fault   <= fault_d;
            mem_wren    <= wren_d;
            mem_address <= addr_d;
            mem_data    <= dat_d;
            mem_byteena <= be_d;
        end
    end

endmodule

// File: tb/tb_ram_lsu_master.sv
// Directed table-driven bench for ram_lsu_master with a behavioural RAM on the memory port.
// Latency is counted in clock edges from accept to the rsp_valid sample.
// Reset-state and mid-operation reset are hand-written sequences.
module tb_ram_lsu_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_fault;
    logic [31:0] rsp_rdata;
    logic        mem_wren;
    logic [29:0] mem_address;
    logic [31:0] mem_data;
    logic [3:0]  mem_byteena;
    logic [31:0] mem_q;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_lsu_master #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_fault(rsp_fault), .mem_wren(mem_wren), .mem_address(mem_address),
        .mem_data(mem_data), .mem_byteena(mem_byteena), .mem_q(mem_q)
    );

    // RAM with registered read address, byte-enabled write
    logic [31:0] ram [0:255] = '{default: 32'd0};
    logic [7:0]  ram_a = 8'd0;
    always @(posedge clk) begin
        if (mem_wren)
            for (int b = 0; b < 4; b++)
                if (mem_byteena[b]) ram[mem_address[7:0]][8*b +: 8] <= mem_data[8*b +: 8];
        ram_a <= mem_address[7:0];
    end
    assign mem_q = ram[ram_a];

    typedef struct {
        string       nm;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        flt;
        logic [31:0] rdata;
        int          lat;
        int          wr_n;
        logic [29:0] a1;
        logic [3:0]  be1;
        logic [31:0] d1;
        logic        chk2;
        logic [29:0] a2;
        logic [3:0]  be2;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input string nm, input logic we, input logic [1:0] size,
                                input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic flt, input logic [31:0] rdata, input int lat, input int wr_n,
                                input logic [29:0] a1, input logic [3:0] be1, input logic [31:0] d1,
                                input logic chk2, input logic [29:0] a2, input logic [3:0] be2);
        vec_t v;
        v.nm = nm; v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.flt = flt; v.rdata = rdata; v.lat = lat; v.wr_n = wr_n; v.a1 = a1; v.be1 = be1;
        v.d1 = d1; v.chk2 = chk2; v.a2 = a2; v.be2 = be2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          lat, wr;
        logic [29:0] a1, a2;
        logic [3:0]  be1, be2;
        logic [31:0] d1, rd;
        logic        ft;
        lat = 0; wr = 0; a1 = '0; a2 = '0; be1 = '0; be2 = '0; d1 = '0; rd = '0; ft = 1'b0;
        @(negedge clk);
        chk({v.nm, ".ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = v.we; req_size = v.size; req_signed = v.sgn;
        req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk);
        #1;
        // scramble the request bus: the DUT must use its captured copy
        req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
        req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        for (int n = 1; n <= 10; n++) begin
            if (n == 1) begin a1 = mem_address; be1 = mem_byteena; d1 = mem_data; end
            if (n == 2) begin a2 = mem_address; be2 = mem_byteena; end
            if (mem_wren) wr++;
            if (rsp_valid) begin
                lat = n; rd = rsp_rdata; ft = rsp_fault;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk({v.nm, ".latency"}, 32'(lat), 32'(v.lat));
        chk({v.nm, ".fault"}, 32'(ft), 32'(v.flt));
        chk({v.nm, ".rdata"}, rd, v.rdata);
        chk({v.nm, ".wren_cycles"}, 32'(wr), 32'(v.wr_n));
        chk({v.nm, ".addr1"}, 32'(a1), 32'(v.a1));
        if (!v.flt) chk({v.nm, ".be1"}, 32'(be1), 32'(v.be1));
        if (v.wr_n > 0) chk({v.nm, ".data1"}, d1, v.d1);
        if (v.chk2) begin
            chk({v.nm, ".addr2"}, 32'(a2), 32'(v.a2));
            chk({v.nm, ".be2"}, 32'(be2), 32'(v.be2));
        end
        @(posedge clk);
        #1;
        chk({v.nm, ".pulse_end"}, 32'(rsp_valid), 32'd0);
        chk({v.nm, ".ready_again"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        //            name        we size sgn addr           wdata          flt rdata          lat wr a1           be1      d1            chk2  a2     be2
        vq.push_back(mk("st_w40",  1, 2, 0, 32'h40,       32'h11223344, 0, 32'h0,        2, 1, 30'h10,      4'b1111, 32'h11223344, 0, 30'h0, 4'h0));
        vq.push_back(mk("st_b43",  1, 0, 0, 32'h43,       32'h000000AB, 0, 32'h0,        2, 1, 30'h10,      4'b1000, 32'hAB000000, 0, 30'h0, 4'h0));
        vq.push_back(mk("ld_w40",  0, 2, 0, 32'h40,       32'h0,        0, 32'hAB223344, 3, 0, 30'h10,      4'b1111, 32'h0,        0, 30'h0, 4'h0));
        vq.push_back(mk("ld_sb43", 0, 0, 1, 32'h43,       32'h0,        0, 32'hFFFFFFAB, 3, 0, 30'h10,      4'b1000, 32'h0,        0, 30'h0, 4'h0));
        vq.push_back(mk("ld_ub43", 0, 0, 0, 32'h43,       32'h0,        0, 32'h000000AB, 3, 0, 30'h10,      4'b1000, 32'h0,        0, 30'h0, 4'h0));
        vq.push_back(mk("ld_sh42", 0, 1, 1, 32'h42,       32'h0,        0, 32'hFFFFAB22, 3, 0, 30'h10,      4'b1100, 32'h0,        0, 30'h0, 4'h0));
        vq.push_back(mk("ld_uh40", 0, 1, 0, 32'h40,       32'h0,        0, 32'h00003344, 3, 0, 30'h10,      4'b0011, 32'h0,        0, 30'h0, 4'h0));
        vq.push_back(mk("ld_sb41", 0, 0, 1, 32'h41,       32'h0,        0, 32'h00000033, 3, 0, 30'h10,      4'b0010, 32'h0,        0, 30'h0, 4'h0));
`ifndef LSU_SPLIT_EN
        vq.push_back(mk("ld_h41f", 0, 1, 0, 32'h41,       32'h0,        1, 32'h0,        1, 0, 30'h10,      4'h0,    32'h0,        0, 30'h0, 4'h0));
`endif
        vq.push_back(mk("rsvd",    0, 3, 0, 32'h40,       32'h0,        1, 32'h0,        1, 0, 30'h10,      4'h0,    32'h0,        0, 30'h0, 4'h0));
`ifndef LSU_SPLIT_EN
        vq.push_back(mk("st_w42f", 1, 2, 0, 32'h42,       32'hDEADBEEF, 1, 32'h0,        1, 0, 30'h10,      4'h0,    32'h0,        0, 30'h0, 4'h0));
`endif
        vq.push_back(mk("ld_w40b", 0, 2, 0, 32'h40,       32'h0,        0, 32'hAB223344, 3, 0, 30'h10,      4'b1111, 32'h0,        0, 30'h0, 4'h0));
        vq.push_back(mk("st_h42",  1, 1, 0, 32'h42,       32'h1234BEEF, 0, 32'h0,        2, 1, 30'h10,      4'b1100, 32'hBEEF0000, 0, 30'h0, 4'h0));
        vq.push_back(mk("ld_w40c", 0, 2, 0, 32'h40,       32'h0,        0, 32'hBEEF3344, 3, 0, 30'h10,      4'b1111, 32'h0,        0, 30'h0, 4'h0));
`ifdef LSU_SPLIT_EN
        vq.push_back(mk("st_w44",  1, 2, 0, 32'h44,       32'h55667788, 0, 32'h0,        2, 1, 30'h11,      4'b1111, 32'h55667788, 0, 30'h0, 4'h0));
        vq.push_back(mk("ld_w42s", 0, 2, 0, 32'h42,       32'h0,        0, 32'h7788BEEF, 4, 0, 30'h10,      4'b1100, 32'h0,        1, 30'h11, 4'b0011));
        vq.push_back(mk("st_wrap", 1, 2, 0, 32'hFFFFFFFE, 32'hCAFEF00D, 0, 32'h0,        3, 2, 30'h3FFFFFFF, 4'b1100, 32'hF00D0000, 1, 30'h0, 4'b0011));
        vq.push_back(mk("ld_wrap", 0, 2, 0, 32'hFFFFFFFE, 32'h0,        0, 32'hCAFEF00D, 4, 0, 30'h3FFFFFFF, 4'b1100, 32'h0,        1, 30'h0, 4'b0011));
`endif

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;

        // outputs while held in reset
        #3;
        chk("rst.ready", 32'(req_ready), 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_fault", 32'(rsp_fault), 32'd0);
        chk("rst.rsp_rdata", rsp_rdata, 32'd0);
        chk("rst.mem_wren", 32'(mem_wren), 32'd0);
        chk("rst.mem_address", 32'(mem_address), 32'd0);
        chk("rst.mem_data", mem_data, 32'd0);
        chk("rst.mem_byteena", 32'(mem_byteena), 32'd0);
        @(posedge clk);
        #1;
        chk("rst.ready_held", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.ready_release", 32'(req_ready), 32'd1);

        foreach (vq[i]) run_vec(vq[i]);

        // reset asserted while a store sits in ISSUE
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h80; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("mid.wren_issue", 32'(mem_wren), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid.wren_drop", 32'(mem_wren), 32'd0);
        chk("mid.ready_rst", 32'(req_ready), 32'd0);
        chk("mid.no_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("mid.no_rsp2", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid.ready_release", 32'(req_ready), 32'd1);
        chk("mid.no_rsp3", 32'(rsp_valid), 32'd0);
        run_vec(mk("mid_ld80",  0, 2, 0, 32'h80, 32'h0,        0, 32'h0,        3, 0, 30'h20, 4'b1111, 32'h0,        0, 30'h0, 4'h0));
        run_vec(mk("mid_st80",  1, 2, 0, 32'h80, 32'h01020304, 0, 32'h0,        2, 1, 30'h20, 4'b1111, 32'h01020304, 0, 30'h0, 4'h0));
        run_vec(mk("mid_ld80b", 0, 2, 0, 32'h80, 32'h0,        0, 32'h01020304, 3, 0, 30'h20, 4'b1111, 32'h0,        0, 30'h0, 4'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
